// File: rtl/voice_alloc.sv
// voice_alloc: four-voice note allocator with LRU stealing.
// Accepts note-on/off events over valid/ready and drives per-voice gate and
// 16-bit phase increment (48 kHz ramp wrapping at 60000) to the ramp generators.
//
// state  | meaning
// IDLE   | ready for an event; accept latches note and on/off
// LOOKUP | compute increment, match and free masks for the latched note
// DECIDE | commit note-off / retouch / free-voice assign, or start a steal
// STEAL  | victim gate was dropped last cycle; load the new note into it
module voice_alloc #(
  parameter int NUM_VOICES = 4
) (
  input  logic        iCLK_18_4,
  input  logic        iRST_N,
  input  logic        iEvt_Valid,
  output logic        oEvt_Ready,
  input  logic [6:0]  iEvt_Note,
  input  logic        iEvt_On,
  input  logic        iPanic,
  output logic        key1_on,
  output logic        key2_on,
  output logic        key3_on,
  output logic        key4_on,
  output logic [15:0] sound1,
  output logic [15:0] sound2,
  output logic [15:0] sound3,
  output logic [15:0] sound4,
  output logic [3:0]  oActive
);

  localparam logic [1:0] OLDEST = 2'(NUM_VOICES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_DECIDE, S_STEAL} state_t;

  state_t      r_state;
  logic        r_ready;
  logic [6:0]  r_evt_note;
  logic        r_evt_on;
  logic [15:0] r_new_incr;
  logic [3:0]  r_match;
  logic [3:0]  r_free;
  logic [1:0]  r_victim;
  logic [3:0]  r_active;
  logic [6:0]  r_note [NUM_VOICES];
  logic [15:0] r_incr [NUM_VOICES];
  logic [1:0]  r_rank [NUM_VOICES];

  logic [6:0]  w_k;
  logic [6:0]  w_s;
  logic [6:0]  w_shift;
  logic [15:0] w_incr;
  logic        w_has_match;
  logic [1:0]  w_match_idx;
  logic        w_has_free;
  logic [1:0]  w_free_idx;
  logic [1:0]  w_oldest_idx;
  logic        w_touch_en;
  logic [1:0]  w_touch_idx;

  // Top-octave increment for each semitone C..B; lower octaves shift right.
  function automatic logic [15:0] semitone_incr(input logic [6:0] s);
    case (s)
      7'd0:    semitone_incr = 16'd10465;
      7'd1:    semitone_incr = 16'd11087;
      7'd2:    semitone_incr = 16'd11747;
      7'd3:    semitone_incr = 16'd12445;
      7'd4:    semitone_incr = 16'd13185;
      7'd5:    semitone_incr = 16'd13969;
      7'd6:    semitone_incr = 16'd14800;
      7'd7:    semitone_incr = 16'd15680;
      7'd8:    semitone_incr = 16'd16612;
      7'd9:    semitone_incr = 16'd17600;
      7'd10:   semitone_incr = 16'd18647;
      7'd11:   semitone_incr = 16'd19755;
      default: semitone_incr = 16'd0;
    endcase
  endfunction

  // Increment lookup and lowest-index priority picks for match/free/oldest.
  always_comb begin
    w_k          = r_evt_note / 7'd12;
    w_s          = r_evt_note % 7'd12;
    w_shift      = 7'd10 - w_k;
    w_incr       = semitone_incr(w_s) >> w_shift;
    w_has_match  = 1'b0;
    w_match_idx  = 2'd0;
    w_has_free   = 1'b0;
    w_free_idx   = 2'd0;
    w_oldest_idx = 2'd0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_match[i]) begin
        w_has_match = 1'b1;
        w_match_idx = 2'(i);
      end
      if (r_free[i]) begin
        w_has_free = 1'b1;
        w_free_idx = 2'(i);
      end
      if (r_rank[i] == OLDEST) w_oldest_idx = 2'(i);
    end
    w_touch_en  = !iPanic &&
                  ((r_state == S_DECIDE && r_evt_on && (w_has_match || w_has_free)) ||
                   r_state == S_STEAL);
    w_touch_idx = (r_state == S_STEAL) ? r_victim :
                  (w_has_match ? w_match_idx : w_free_idx);
  end

  // Event FSM: handshake, lookup, commit and steal sequencing; panic aborts.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_evt_note <= '0;
      r_evt_on   <= 1'b0;
      r_new_incr <= '0;
      r_match    <= '0;
      r_free     <= '0;
      r_victim   <= '0;
      r_active   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i] <= '0;
        r_incr[i] <= '0;
      end
    end else if (iPanic) begin
      r_active <= '0;
      r_state  <= S_IDLE;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iEvt_Valid && r_ready) begin
            r_evt_note <= iEvt_Note;
            r_evt_on   <= iEvt_On;
            r_state    <= S_LOOKUP;
            r_ready    <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_LOOKUP: begin
          r_new_incr <= w_incr;
          for (int i = 0; i < NUM_VOICES; i++) begin
            r_match[i] <= r_active[i] && (r_note[i] == r_evt_note);
            r_free[i]  <= !r_active[i];
          end
          r_state <= S_DECIDE;
        end
        S_DECIDE: begin
          if (!r_evt_on) begin
            r_active <= r_active & ~r_match;
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
          end else if (w_has_match) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else if (w_has_free) begin
            r_active[w_free_idx] <= 1'b1;
            r_note[w_free_idx]   <= r_evt_note;
            r_incr[w_free_idx]   <= r_new_incr;
            r_state              <= S_IDLE;
            r_ready              <= 1'b1;
          end else begin
            // Drop the gate for one cycle so the ramp restarts from zero.
            r_active[w_oldest_idx] <= 1'b0;
            r_victim               <= w_oldest_idx;
            r_state                <= S_STEAL;
          end
        end
        S_STEAL: begin
          r_active[r_victim] <= 1'b1;
          r_note[r_victim]   <= r_evt_note;
          r_incr[r_victim]   <= r_new_incr;
          r_state            <= S_IDLE;
          r_ready            <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // LRU ranks: touched voice becomes 0, younger voices age by one.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < NUM_VOICES; i++) r_rank[i] <= 2'(i);
    end else if (w_touch_en) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (2'(i) == w_touch_idx) r_rank[i] <= 2'd0;
        else if (r_rank[i] < r_rank[w_touch_idx]) r_rank[i] <= r_rank[i] + 2'd1;
      end
    end
  end

  assign oEvt_Ready = r_ready;
  assign oActive    = r_active;
  assign key1_on    = r_active[0];
  assign key2_on    = r_active[1];
  assign key3_on    = r_active[2];
  assign key4_on    = r_active[3];
  assign sound1     = r_incr[0];
  assign sound2     = r_incr[1];
  assign sound3     = r_incr[2];
  assign sound4     = r_incr[3];

endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc: directed steps then random events against a queue-based
// LRU model of the allocator.
module tb_voice_alloc;

  logic        iCLK_18_4 = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iEvt_Valid = 1'b0;
  logic [6:0]  iEvt_Note = '0;
  logic        iEvt_On = 1'b0;
  logic        iPanic = 1'b0;
  logic        oEvt_Ready;
  logic        key1_on, key2_on, key3_on, key4_on;
  logic [15:0] sound1, sound2, sound3, sound4;
  logic [3:0]  oActive;

  voice_alloc #(.NUM_VOICES(4)) dut (
    .iCLK_18_4(iCLK_18_4), .iRST_N(iRST_N),
    .iEvt_Valid(iEvt_Valid), .oEvt_Ready(oEvt_Ready),
    .iEvt_Note(iEvt_Note), .iEvt_On(iEvt_On), .iPanic(iPanic),
    .key1_on(key1_on), .key2_on(key2_on), .key3_on(key3_on), .key4_on(key4_on),
    .sound1(sound1), .sound2(sound2), .sound3(sound3), .sound4(sound4),
    .oActive(oActive)
  );

  always #27 iCLK_18_4 = ~iCLK_18_4;

  int errors = 0;
  int checks = 0;

  int tbl[12] = '{10465, 11087, 11747, 12445, 13185, 13969,
                  14800, 15680, 16612, 17600, 18647, 19755};
  bit m_active[4];
  int m_note[4];
  int m_incr[4];
  int lru[$];   // front = most recently touched, back = oldest

  function automatic int calc_incr(int n);
    return tbl[n % 12] >> (10 - n / 12);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_active[i] = 1'b0;
      m_note[i]   = 0;
      m_incr[i]   = 0;
    end
    lru = '{0, 1, 2, 3};
  endfunction

  function automatic void touch(int v);
    for (int j = 0; j < lru.size(); j++) begin
      if (lru[j] == v) begin
        lru.delete(j);
        break;
      end
    end
    lru.push_front(v);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [3:0] ek;
    ek = '0;
    for (int i = 0; i < 4; i++) ek[i] = m_active[i];
    chk({tag, ":keys"}, {28'd0, key4_on, key3_on, key2_on, key1_on}, {28'd0, ek});
    chk({tag, ":oActive"}, {28'd0, oActive}, {28'd0, ek});
    chk({tag, ":sound1"}, {16'd0, sound1}, m_incr[0]);
    chk({tag, ":sound2"}, {16'd0, sound2}, m_incr[1]);
    chk({tag, ":sound3"}, {16'd0, sound3}, m_incr[2]);
    chk({tag, ":sound4"}, {16'd0, sound4}, m_incr[3]);
  endtask

  // One event through the handshake, checking outputs at every cycle after accept.
  task automatic send(int n, bit on);
    int waited;
    int hit;
    int victim;
    bit stole;
    waited = 0;
    stole  = 1'b0;
    victim = 0;
    @(negedge iCLK_18_4);
    while (!oEvt_Ready && waited < 20) begin
      @(negedge iCLK_18_4);
      waited++;
    end
    chk("ready_wait", {31'd0, oEvt_Ready}, 1);
    iEvt_Valid = 1'b1;
    iEvt_Note  = 7'(n);
    iEvt_On    = on;
    @(posedge iCLK_18_4);
    @(negedge iCLK_18_4);
    iEvt_Valid = 1'b0;
    chk("ready_low", {31'd0, oEvt_Ready}, 0);
    check_all("acc+0");
    @(negedge iCLK_18_4);
    check_all("acc+1");
    if (!on) begin
      for (int i = 0; i < 4; i++)
        if (m_active[i] && m_note[i] == n) m_active[i] = 1'b0;
    end else begin
      hit = -1;
      for (int i = 3; i >= 0; i--) if (m_active[i] && m_note[i] == n) hit = i;
      if (hit >= 0) begin
        touch(hit);
      end else begin
        for (int i = 3; i >= 0; i--) if (!m_active[i]) hit = i;
        if (hit >= 0) begin
          m_active[hit] = 1'b1;
          m_note[hit]   = n;
          m_incr[hit]   = calc_incr(n);
          touch(hit);
        end else begin
          stole  = 1'b1;
          victim = lru[3];
          m_active[victim] = 1'b0;
        end
      end
    end
    @(negedge iCLK_18_4);
    check_all("acc+2");
    if (stole) begin
      m_active[victim] = 1'b1;
      m_note[victim]   = n;
      m_incr[victim]   = calc_incr(n);
      touch(victim);
      @(negedge iCLK_18_4);
      check_all("acc+3");
    end
    chk("ready_back", {31'd0, oEvt_Ready}, 1);
  endtask

  // Panic pulse with a note-on offered during it; nothing may be accepted.
  task automatic panic();
    @(negedge iCLK_18_4);
    iPanic     = 1'b1;
    iEvt_Valid = 1'b1;
    iEvt_Note  = 7'd50;
    iEvt_On    = 1'b1;
    @(posedge iCLK_18_4);
    @(negedge iCLK_18_4);
    for (int i = 0; i < 4; i++) m_active[i] = 1'b0;
    check_all("panic");
    chk("panic_ready", {31'd0, oEvt_Ready}, 0);
    iPanic     = 1'b0;
    iEvt_Valid = 1'b0;
    @(negedge iCLK_18_4);
    chk("post_panic_ready", {31'd0, oEvt_Ready}, 1);
    repeat (3) @(negedge iCLK_18_4);
    check_all("post_panic");
  endtask

  initial begin
    #(54 * 40000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int n;
    model_reset();
    repeat (3) @(negedge iCLK_18_4);
    check_all("reset");
    iRST_N = 1'b1;
    @(negedge iCLK_18_4);
    chk("reset_ready", {31'd0, oEvt_Ready}, 1);

    send(69, 1'b1);
    chk("note69_sound1", {16'd0, sound1}, 550);
    chk("note69_oActive", {28'd0, oActive}, 4'b0001);
    send(69, 1'b0);

    send(60, 1'b1);
    send(64, 1'b1);
    send(67, 1'b1);
    send(72, 1'b1);
    chk("fill_sound1", {16'd0, sound1}, 327);
    chk("fill_sound2", {16'd0, sound2}, 412);
    chk("fill_sound3", {16'd0, sound3}, 490);
    chk("fill_sound4", {16'd0, sound4}, 654);
    send(76, 1'b1);
    chk("steal_sound1", {16'd0, sound1}, 824);

    send(64, 1'b0);
    chk("off64_oActive", {28'd0, oActive}, 4'b1101);
    send(64, 1'b0);
    chk("off64_again", {28'd0, oActive}, 4'b1101);

    send(67, 1'b1);
    send(80, 1'b1);
    send(84, 1'b1);
    chk("steal_oldest_sound4", {16'd0, sound4}, 1308);
    chk("steal_oldest_sound3", {16'd0, sound3}, 490);

    panic();
    send(0, 1'b1);
    send(127, 1'b1);
    send(11, 1'b1);
    send(120, 1'b1);
    chk("bnd_note0", {16'd0, sound1}, 10);
    chk("bnd_note127", {16'd0, sound2}, 15680);
    chk("bnd_note11", {16'd0, sound3}, 19);
    chk("bnd_note120", {16'd0, sound4}, 10465);

    panic();
    send(40, 1'b1);

    // Reset while the event sits in DECIDE.
    @(negedge iCLK_18_4);
    iEvt_Valid = 1'b1;
    iEvt_Note  = 7'd45;
    iEvt_On    = 1'b1;
    @(posedge iCLK_18_4);
    @(negedge iCLK_18_4);
    iEvt_Valid = 1'b0;
    @(posedge iCLK_18_4);
    #5 iRST_N = 1'b0;
    #1;
    model_reset();
    check_all("reset_in_decide");
    @(negedge iCLK_18_4);
    iRST_N = 1'b1;
    @(negedge iCLK_18_4);
    chk("rst2_ready", {31'd0, oEvt_Ready}, 1);

    for (int it = 0; it < 90; it++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        panic();
      end else begin
        n = (r == 1) ? $urandom_range(0, 127) : $urandom_range(55, 62);
        send(n, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
